// File: rtl/nn_frame_driver.sv
// nn_frame_driver: collects four signed 5-bit samples into a vector, strobes
// the inference core once, waits for both results (with a timeout), then
// returns out0 and out1 serially on a valid/ready stream.
//
// state   | meaning
// --------+-------------------------------------------------------------
// COLLECT | accepting samples into the buffer; s_ready high
// FIRE    | one-cycle in_ready strobe; x0..x3 already hold the new vector
// WAIT    | waiting for out0_ready && out1_ready; timeout timer running
// SEND0   | presenting captured out0 (m_last=0)
// SEND1   | presenting captured out1 (m_last=1)
module nn_frame_driver #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [4:0]  s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic signed [4:0]  x0,
  output logic signed [4:0]  x1,
  output logic signed [4:0]  x2,
  output logic signed [4:0]  x3,
  output logic               in_ready,
  input  logic signed [16:0] out0,
  input  logic signed [16:0] out1,
  input  logic               out0_ready,
  input  logic               out1_ready,
  output logic signed [16:0] m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_last,
  output logic               busy,
  output logic               timeout_err
);

  typedef enum logic [2:0] {
    COLLECT = 3'd0,
    FIRE    = 3'd1,
    WAIT    = 3'd2,
    SEND0   = 3'd3,
    SEND1   = 3'd4
  } state_t;

  // The timer is a down-counter: loaded in FIRE so that WAIT lasts at most
  // TIMEOUT cycles, expiring on the cycle it reads zero.
  localparam logic [CNT_W-1:0] TC_LOAD = CNT_W'(TIMEOUT - 1);

  state_t                state;
  state_t                state_nxt;
  logic [1:0]            cnt;
  logic signed [4:0]     smp0;
  logic signed [4:0]     smp1;
  logic signed [4:0]     smp2;
  logic [CNT_W-1:0]      wait_cnt;
  logic signed [16:0]    res0;
  logic signed [16:0]    res1;
  logic                  accept;
  logic                  capture;
  logic                  expire;

  // s_ready is forced low while rst is held so nothing is accepted in the reset cycle.
  assign s_ready  = (state == COLLECT) && !rst;
  assign accept   = s_valid && s_ready;
  assign capture  = (state == WAIT) && out0_ready && out1_ready;
  assign expire   = (state == WAIT) && !capture && (wait_cnt == '0);

  assign in_ready = (state == FIRE);
  assign m_valid  = (state == SEND0) || (state == SEND1);
  assign m_last   = (state == SEND1);
  assign busy     = (state != COLLECT);
  assign m_data   = (state == SEND1) ? res1 :
                    (state == SEND0) ? res0 : '0;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (accept && (cnt == 2'd3)) state_nxt = FIRE;
      FIRE:    state_nxt = WAIT;
      WAIT: begin
        if (capture)     state_nxt = SEND0;
        else if (expire) state_nxt = COLLECT;
      end
      SEND0:   if (m_ready) state_nxt = SEND1;
      SEND1:   if (m_ready) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  // Sample buffer, vector registers, timer, result capture and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      smp0        <= '0;
      smp1        <= '0;
      smp2        <= '0;
      x0          <= '0;
      x1          <= '0;
      x2          <= '0;
      x3          <= '0;
      wait_cnt    <= '0;
      res0        <= '0;
      res1        <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (accept) begin
        case (cnt)
          2'd0: smp0 <= s_data;
          2'd1: smp1 <= s_data;
          2'd2: smp2 <= s_data;
          default: begin
            // Fourth sample goes straight to x3; the vector updates on the FIRE edge.
            x0 <= smp0;
            x1 <= smp1;
            x2 <= smp2;
            x3 <= s_data;
          end
        endcase
        cnt <= cnt + 2'd1;
      end

      if (state == FIRE)
        wait_cnt <= TC_LOAD;
      else if ((state == WAIT) && (wait_cnt != '0))
        wait_cnt <= wait_cnt - CNT_W'(1);

      if (capture) begin
        res0 <= out0;
        res1 <= out1;
      end

      if (expire)
        timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nn_frame_driver.sv
// Bench for nn_frame_driver: directed frames, a stub core, and a queue-based
// reference model compared against every output on every cycle.
module tb_nn_frame_driver;
  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 8;

  logic clk = 1'b0;
  logic rst;
  logic signed [4:0]  s_data;
  logic               s_valid;
  logic               s_ready;
  logic signed [4:0]  x0, x1, x2, x3;
  logic               in_ready;
  logic signed [16:0] out0, out1;
  logic               out0_ready, out1_ready;
  logic signed [16:0] m_data;
  logic               m_valid;
  logic               m_ready;
  logic               m_last;
  logic               busy;
  logic               timeout_err;

  always #5 clk = ~clk;

  nn_frame_driver #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3), .in_ready(in_ready),
    .out0(out0), .out1(out1), .out0_ready(out0_ready), .out1_ready(out1_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .timeout_err(timeout_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", nm, $time);
  endtask

  // Stub core: 0 normal (answer 3 cycles after in_ready), 1 silent,
  // 2 lone out0_ready first then both 2 cycles later, 3 answer long after timeout.
  int core_mode = 0;
  logic signed [16:0] core_r0 = '0;
  logic signed [16:0] core_r1 = '0;

  // Stub core process.
  initial begin
    out0 = '0; out1 = '0; out0_ready = 1'b0; out1_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (in_ready === 1'b1 && core_mode != 1) begin
        if (core_mode == 3) repeat (TIMEOUT + 5) @(negedge clk);
        else                repeat (3) @(negedge clk);
        out0 = core_r0;
        out1 = core_r1;
        if (core_mode == 2) begin
          out0_ready = 1'b1;
          @(negedge clk);
          out0_ready = 1'b0;
          @(negedge clk);
        end
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        @(negedge clk);
        out0_ready = 1'b0;
        out1_ready = 1'b0;
      end
    end
  end

  // Reference model: samples gathered in a queue, a pending-fire flag, an
  // elapsed-wait age, and a queue of result words still to be delivered.
  logic signed [4:0]  mq[$];
  logic signed [4:0]  mx[4];
  logic signed [16:0] mout[$];
  bit                 mfire = 0;
  bit                 mwait = 0;
  int                 mage  = 0;
  bit                 merr  = 0;

  task automatic model_step();
    if (rst) begin
      mq.delete();
      mout.delete();
      for (int i = 0; i < 4; i++) mx[i] = '0;
      mfire = 0; mwait = 0; mage = 0; merr = 0;
    end else if (mout.size() > 0) begin
      if (m_ready) void'(mout.pop_front());
    end else if (mwait) begin
      if (out0_ready && out1_ready) begin
        mout.push_back(out0);
        mout.push_back(out1);
        mwait = 0;
      end else begin
        mage++;
        if (mage == TIMEOUT) begin
          merr  = 1;
          mwait = 0;
        end
      end
    end else if (mfire) begin
      mfire = 0;
      mwait = 1;
      mage  = 0;
    end else if (s_valid) begin
      mq.push_back(s_data);
      if (mq.size() == 4) begin
        for (int i = 0; i < 4; i++) mx[i] = mq[i];
        mq.delete();
        mfire = 1;
      end
    end
  endtask

  // Observed output words and the cycle each handshake completed.
  logic [17:0] got[$];
  int          got_cyc[$];
  int          cyc = 0;
  int          fire_cyc = -1;
  int          err_cyc = -1;
  int          in_cnt = 0;
  logic        prev_in = 1'b0;
  logic        prev_err = 1'b0;
  logic        pend_v = 1'b0;
  logic [17:0] pend_w = '0;

  // Compare process: advance the model at each edge, check every output just after.
  initial begin
    bit col;
    for (int i = 0; i < 4; i++) mx[i] = '0;
    forever begin
      @(posedge clk);
      if (pend_v && m_ready === 1'b1) begin
        got.push_back(pend_w);
        got_cyc.push_back(cyc);
      end
      model_step();
      cyc++;
      #1;
      col = !mfire && !mwait && (mout.size() == 0);
      chk("s_ready",     s_ready,     !rst && col);
      chk("in_ready",    in_ready,    mfire);
      chk("busy",        busy,        !col);
      chk("m_valid",     m_valid,     mout.size() > 0);
      chk("m_last",      m_last,      mout.size() == 1);
      chk("m_data",      m_data,      (mout.size() > 0) ? mout[0] : 17'sd0);
      chk("timeout_err", timeout_err, merr);
      chk("x0", x0, mx[0]);
      chk("x1", x1, mx[1]);
      chk("x2", x2, mx[2]);
      chk("x3", x3, mx[3]);
      pend_v = (m_valid === 1'b1);
      pend_w = {m_last, m_data};
      if (in_ready === 1'b1 && prev_in !== 1'b1) begin
        in_cnt++;
        fire_cyc = cyc;
      end
      if (timeout_err === 1'b1 && prev_err !== 1'b1) err_cyc = cyc;
      prev_in  = in_ready;
      prev_err = timeout_err;
    end
  end

  task automatic put(input int v);
    int g;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 5'(v);
    g = 0;
    while (s_ready !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) bound_fail("put");
  endtask

  task automatic end_input();
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic send_frame(input int a, input int b, input int c, input int d);
    put(a); put(b); put(c); put(d);
    end_input();
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy !== 1'b0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) bound_fail("wait_idle");
  endtask

  task automatic chk_words(input string nm, input int w0, input int w1);
    chk({nm, "_count"}, got.size(), 2);
    if (got.size() >= 2) begin
      chk({nm, "_w0"},    $signed(got[0][16:0]), w0);
      chk({nm, "_last0"}, got[0][17], 1'b0);
      chk({nm, "_w1"},    $signed(got[1][16:0]), w1);
      chk({nm, "_last1"}, got[1][17], 1'b1);
    end
  endtask

  task automatic chk_x(input string nm, input int a, input int b, input int c, input int d);
    chk({nm, "_x0"}, x0, a);
    chk({nm, "_x1"}, x1, b);
    chk({nm, "_x2"}, x2, c);
    chk({nm, "_x3"}, x3, d);
  endtask

  // Directed stimulus.
  initial begin
    logic pat [7];
    int   vals [4];
    int   k;
    int   g;
    int   in_before;

    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    @(negedge clk);
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_err", timeout_err, 1'b0);
    chk_x("rst", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_s_ready", s_ready, 1'b1);

    // Basic frame.
    core_mode = 0; core_r0 = 17'sd100; core_r1 = -17'sd5;
    got.delete(); got_cyc.delete();
    send_frame(1, 2, -3, 4);
    wait_idle();
    chk_x("basic", 1, 2, -3, 4);
    chk_words("basic", 100, -5);
    chk("basic_in_pulses", in_cnt, 1);
    if (got_cyc.size() >= 2) chk("basic_send_gap", got_cyc[1] - got_cyc[0], 1);

    // Backpressure in SEND0.
    m_ready = 1'b0;
    got.delete(); got_cyc.delete();
    send_frame(1, 2, -3, 4);
    g = 0;
    while (m_valid !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) bound_fail("bp_m_valid");
    for (int i = 0; i < 5; i++) begin
      chk("bp_m_valid", m_valid, 1'b1);
      chk("bp_m_data", m_data, 100);
      chk("bp_s_ready", s_ready, 1'b0);
      @(negedge clk);
    end
    m_ready = 1'b1;
    wait_idle();
    chk_words("bp", 100, -5);

    // Gapped input.
    core_r0 = 17'sd300; core_r1 = -17'sd300;
    got.delete(); got_cyc.delete();
    in_before = in_cnt;
    pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vals = '{7, -8, 0, 15};
    k = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      s_valid = pat[i];
      s_data  = pat[i] ? 5'(vals[k]) : 5'(-1);
      if (pat[i]) k++;
    end
    end_input();
    chk("gap_in_ready", in_ready, 1'b1);
    wait_idle();
    chk_x("gap", 7, -8, 0, 15);
    chk("gap_in_pulses", in_cnt - in_before, 1);
    chk_words("gap", 300, -300);

    // Lone out0_ready, then dual strobe with extreme values.
    core_mode = 2; core_r0 = -17'sd65536; core_r1 = 17'sd65535;
    got.delete(); got_cyc.delete();
    send_frame(5, 6, 7, 8);
    wait_idle();
    chk_words("partial", -65536, 65535);

    // Timeout: core answers only long after the window closes.
    core_mode = 3;
    got.delete(); got_cyc.delete();
    send_frame(1, 1, 1, 1);
    wait_idle();
    chk("to_err", timeout_err, 1'b1);
    chk("to_s_ready", s_ready, 1'b1);
    chk("to_latency", err_cyc - fire_cyc, TIMEOUT + 1);
    repeat (10) @(negedge clk);
    chk("to_late_words", got.size(), 0);
    chk("to_late_busy", busy, 1'b0);
    chk("to_err_sticky", timeout_err, 1'b1);

    // Reset while waiting, then a clean frame.
    core_mode = 0; core_r0 = 17'sd11; core_r1 = -17'sd11;
    got.delete(); got_cyc.delete();
    send_frame(9, -9, 9, -9);
    @(negedge clk);
    chk("mid_in_wait", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_busy", busy, 1'b0);
    chk("mid_in_ready", in_ready, 1'b0);
    chk("mid_m_valid", m_valid, 1'b0);
    chk("mid_err", timeout_err, 1'b0);
    chk("mid_s_ready", s_ready, 1'b0);
    chk_x("mid", 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    chk("mid_s_ready_after", s_ready, 1'b1);
    core_r0 = 17'sd21; core_r1 = -17'sd21;
    send_frame(3, 3, 3, 3);
    wait_idle();
    chk_x("after_rst", 3, 3, 3, 3);
    chk_words("after_rst", 21, -21);
    chk("after_rst_err", timeout_err, 1'b0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

endmodule
